fir_coef_readback_uart_tx: RTL

//  Coefficient read-back transmitter for the FIR coefficient bank. It is the return

---
 rtl/fir_coef_readback_uart_tx_if.sv | 12 +
 rtl/fir_coef_readback_uart_tx.sv | 83 ++++++++
 2 files changed

// File: rtl/fir_coef_readback_uart_tx_if.sv
// fir_coef_readback_uart_tx_if: synchronous read port of the FIR coefficient bank
interface fir_coef_readback_uart_tx_if #(
    parameter int ADDR_W = 4,
    parameter int COEF_W = 12
);
    logic [ADDR_W-1:0] coef_addr;
    logic              coef_rd;
    logic [COEF_W-1:0] coef_data;

    modport master (output coef_addr, coef_rd, input coef_data);
    modport slave (input coef_addr, coef_rd, output coef_data);
endinterface

// File: rtl/fir_coef_readback_uart_tx.sv
// fir_coef_readback_uart_tx: dumps every coefficient tap as two sign-extended bytes over UART 8N1
module fir_coef_readback_uart_tx #(
    parameter int N_COEF   = 16,
    parameter int COEF_W   = 12,
    parameter int ADDR_W   = 4,
    parameter int BAUD_DIV = 868
) (
    input  logic clk_100MHz_i,
    input  logic rst_n_i,
    input  logic send_i,
    input  logic coef_lock_i,
    fir_coef_readback_uart_tx_if.master bank,
    output logic tx_o,
    output logic busy_o,
    output logic done_o
);
    localparam int CNT_W = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {IDLE, RD, CAP, START, DATA, STOP} state_t;

    state_t            state, state_nx;
    logic              send_q;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic              lo;
    logic [ADDR_W-1:0] tap;
    logic [15:0]       word;
    logic              accept, baud_end, last_tap, stop_end;

    assign accept   = send_i & ~send_q & ~coef_lock_i & (state == IDLE);
    assign baud_end = baud_cnt == CNT_W'(BAUD_DIV - 1);
    assign last_tap = tap == ADDR_W'(N_COEF - 1);
    assign stop_end = (state == STOP) & baud_end;
    assign bank.coef_addr = tap;

    // state register; reset drops straight to IDLE so tx_o returns high at once
    always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    // next state and frame outputs; high byte goes first, low byte follows with no gap
    always_comb begin
        state_nx     = state;
        bank.coef_rd = state == RD;
        busy_o       = state != IDLE;
        tx_o         = state == START ? 1'b0 : state == DATA ? word[{~lo, bit_idx}] : 1'b1;
        case (state)
            IDLE:    if (accept) state_nx = RD;
            RD:      state_nx = CAP;
            CAP:     state_nx = START;
            START:   if (baud_end) state_nx = DATA;
            DATA:    if (baud_end && bit_idx == 3'd7) state_nx = STOP;
            STOP:    if (baud_end) state_nx = !lo ? START : last_tap ? IDLE : RD;
            default: state_nx = IDLE;
        endcase
    end

    // edge detect, baud/bit/tap counters, captured tap word and done pulse
    always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            send_q   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            lo       <= 1'b0;
            tap      <= '0;
            word     <= '0;
            done_o   <= 1'b0;
        end else begin
            send_q   <= send_i;
            done_o   <= stop_end & lo & last_tap;
            baud_cnt <= (state inside {START, DATA, STOP}) && !baud_end ? baud_cnt + 1'b1 : '0;
            if (state == DATA && baud_end) bit_idx <= bit_idx + 1'b1;
            if (state == CAP) begin
                lo   <= 1'b0;
                word <= 16'(signed'(bank.coef_data));
            end
            if (stop_end) lo <= ~lo;
            if (accept) tap <= '0;
            else if (stop_end && lo && !last_tap) tap <= tap + 1'b1;
        end
    end
endmodule
